video_fetch_ctrl: RTL and testbench

- Sequencer for the video fetch datapath: issues per-window DRAM video word requests and tracks outstanding reads.
- Drives byte-lane selects (f_sel/b_sel) in step with each returned video_strobe, then pulses fetch_stb to commit the assembled 32-bit word at the window boundary.
- Sits between the raster timing generator (line_start, cycle_stb, active) and the DRAM arbiter video channel.

---
 rtl/video_fetch_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_video_fetch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_ctrl.sv
// Video fetch sequencer: issues per-window DRAM word requests, tracks outstanding reads, steers lane selects.
// Lane selects follow each strobe combinationally; fetch_stb/underrun are 1 clk after cycle_stb; requests stall when the queue is full.
module video_fetch_ctrl #(
  parameter int AW = 21,
  parameter int QD = 2
) (
  input  logic          i_clk,
  input  logic          i_res,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_base_a,
  input  logic [AW-1:0] i_base_b,
  input  logic          i_line_start,
  input  logic          i_cycle_stb,
  input  logic          i_active,
  output logic          o_video_req,
  output logic [AW-1:0] o_video_addr,
  input  logic          i_video_next,
  input  logic          i_video_strobe,
  output logic [3:0]    o_f_sel,
  output logic [1:0]    o_b_sel,
  output logic          o_fetch_stb,
  output logic          o_underrun,
  output logic          o_busy
);
  localparam int QW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_q [QD];
  logic [QW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_ptr_a, r_ptr_b;
  logic [7:0]    r_col;
  logic          r_pidx;
  logic          r_ls_pend, r_ur_pend, r_ur_act;
  logic          r_fetch_stb, r_underrun;

  logic       w_is_b, w_last, w_empty, w_full, w_accept, w_pop, w_ptr_inc;
  logic [3:0] w_pf;
  logic [1:0] w_pb;
  logic       w_load, w_win, w_set_ls, w_set_ur;

  // Current plan entry: which stream and which lanes the next requested word feeds.
  always_comb begin
    w_is_b = 1'b0;
    w_pf   = 4'b0011;
    w_pb   = 2'b10;
    w_last = 1'b0;
    case (i_mode)
      2'd0: begin
        if (!r_pidx) begin
          w_pf = 4'b0001;
          w_pb = {1'b0, r_col[0]};
        end else begin
          w_is_b = 1'b1;
          w_pf   = 4'b0010;
          w_pb   = {r_col[0], 1'b0};
          w_last = 1'b1;
        end
      end
      2'd3: w_last = 1'b1;
      default: begin
        if (r_pidx) begin
          w_pf   = 4'b1100;
          w_pb   = 2'b00;
          w_last = 1'b1;
        end
      end
    endcase
  end

  assign w_empty      = (r_cnt == '0);
  assign w_full       = (r_cnt == CW'(QD));
  assign o_video_req  = (r_state == S_REQ) && !w_full;
  assign o_video_addr = w_is_b ? r_ptr_b : r_ptr_a;
  assign w_accept     = o_video_req && i_video_next;
  assign w_pop        = i_video_strobe && !w_empty;
  // ZX mode fetches each pixel/attr word for two consecutive columns.
  assign w_ptr_inc    = (i_mode != 2'd0) || r_col[0];
  assign {o_f_sel, o_b_sel} = w_empty ? 6'd0 : r_q[r_rp];
  assign o_fetch_stb  = r_fetch_stb;
  assign o_underrun   = r_underrun;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_win       = 1'b0;
    w_set_ls    = 1'b0;
    w_set_ur    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_line_start) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_line_start) begin
          w_set_ls    = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (i_cycle_stb) begin
          w_set_ur    = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_accept && w_last) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_line_start) begin
          w_set_ls = 1'b1;
        end else if (i_cycle_stb) begin
          w_set_ur = 1'b1;
        end else if (w_empty) begin
          if (r_ls_pend) begin
            w_load      = 1'b1;
            w_state_nxt = S_REQ;
          end else if (r_ur_pend) begin
            w_win       = r_ur_act;
            w_state_nxt = r_ur_act ? S_REQ : S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_line_start) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end else if (i_cycle_stb) begin
          w_win       = i_active;
          w_state_nxt = i_active ? S_REQ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state     <= S_IDLE;
      r_fetch_stb <= 1'b0;
      r_underrun  <= 1'b0;
      r_ls_pend   <= 1'b0;
      r_ur_pend   <= 1'b0;
      r_ur_act    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_stb <= i_cycle_stb && (r_state != S_IDLE);
      r_underrun  <= w_set_ur;
      if (w_load || w_win || (w_state_nxt == S_IDLE)) begin
        r_ls_pend <= 1'b0;
        r_ur_pend <= 1'b0;
      end else begin
        if (w_set_ls) r_ls_pend <= 1'b1;
        if (w_set_ur) begin
          r_ur_pend <= 1'b1;
          r_ur_act  <= i_active;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_ptr_a <= '0;
      r_ptr_b <= '0;
      r_col   <= '0;
      r_pidx  <= 1'b0;
    end else begin
      if (w_load) begin
        r_ptr_a <= i_base_a;
        r_ptr_b <= i_base_b;
        r_col   <= '0;
      end else begin
        if (w_win) r_col <= r_col + 8'd1;
        if (w_accept && w_ptr_inc) begin
          if (w_is_b) r_ptr_b <= r_ptr_b + 1'b1;
          else        r_ptr_a <= r_ptr_a + 1'b1;
        end
      end
      if (w_load || w_win)  r_pidx <= 1'b0;
      else if (w_accept)    r_pidx <= !w_last;
    end
  end

  // Outstanding-read queue; DRAM returns data in request order.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) r_wp <= (r_wp == QW'(QD - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)    r_rp <= (r_rp == QW'(QD - 1)) ? '0 : r_rp + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) r_q[r_wp] <= {w_pf, w_pb};
  end

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// Directed bench for video_fetch_ctrl: mode0/mode1 windows, underrun, line restart and async reset.
module tb_video_fetch_ctrl;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic [1:0]    mode;
  logic [AW-1:0] base_a, base_b;
  logic          line_start, cycle_stb, active;
  logic          video_req;
  logic [AW-1:0] video_addr;
  logic          video_next, video_strobe;
  logic [3:0]    f_sel;
  logic [1:0]    b_sel;
  logic          fetch_stb, underrun, busy;

  always #5 clk = ~clk;

  video_fetch_ctrl #(.AW(AW), .QD(2)) dut (
    .i_clk(clk), .i_res(res), .i_mode(mode), .i_base_a(base_a), .i_base_b(base_b),
    .i_line_start(line_start), .i_cycle_stb(cycle_stb), .i_active(active),
    .o_video_req(video_req), .o_video_addr(video_addr), .i_video_next(video_next),
    .i_video_strobe(video_strobe), .o_f_sel(f_sel), .o_b_sel(b_sel),
    .o_fetch_stb(fetch_stb), .o_underrun(underrun), .o_busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic          auto_en = 1'b0;
  logic [1:0]    pipe    = 2'b00;
  logic [AW-1:0] addr_log[$];
  logic [5:0]    lane_log[$];

  // One clock: drive at negedge, log accepted addresses and strobed lanes 1ns later.
  // In auto mode the DRAM accepts immediately and strobes 2 clocks after the accept.
  task automatic step(input logic ls, input logic cs, input logic nxt, input logic stb);
    @(negedge clk);
    line_start = ls;
    cycle_stb  = cs;
    if (auto_en) begin
      video_next   = video_req;
      video_strobe = pipe[1];
      pipe         = {pipe[0], video_req};
    end else begin
      video_next   = nxt;
      video_strobe = stb;
    end
    #1;
    if (video_next && video_req) addr_log.push_back(video_addr);
    if (video_strobe) lane_log.push_back({f_sel, b_sel});
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wend(input logic act);
    active = act;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("fetch_on", 32'(fetch_stb), 1);
    check("underrun_off", 32'(underrun), 0);
    if (!act) check("busy_after_idle", 32'(busy), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("fetch_once", 32'(fetch_stb), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   32'(video_req), 0);
    check({tag, "_addr"},  32'(video_addr), 0);
    check({tag, "_fsel"},  32'(f_sel), 0);
    check({tag, "_bsel"},  32'(b_sel), 0);
    check({tag, "_fetch"}, 32'(fetch_stb), 0);
    check({tag, "_ur"},    32'(underrun), 0);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp_a0 [6];
    logic [5:0]    exp_l0 [6];
    mode = 2'd0; base_a = '0; base_b = '0;
    line_start = 1'b0; cycle_stb = 1'b0; active = 1'b0;
    video_next = 1'b0; video_strobe = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    res = 1'b0;

    // Mode 0, three windows with an immediate-accept, 2-clk-latency DRAM.
    exp_a0 = '{21'h100, 21'h200, 21'h100, 21'h200, 21'h101, 21'h201};
    exp_l0 = '{6'b0001_00, 6'b0010_00, 6'b0001_01, 6'b0010_10, 6'b0001_00, 6'b0010_00};
    mode = 2'd0; base_a = 21'h100; base_b = 21'h200; active = 1'b1; auto_en = 1'b1;
    addr_log.delete(); lane_log.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(8);
    wend(1'b1);
    idle_steps(8);
    wend(1'b1);
    idle_steps(8);
    wend(1'b0);
    check("m0_idle_req", 32'(video_req), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("m0_no_fetch_idle", 32'(fetch_stb), 0);
    check("m0_naddr", 32'(addr_log.size()), 6);
    check("m0_nlane", 32'(lane_log.size()), 6);
    for (int i = 0; i < 6 && i < addr_log.size(); i++) check("m0_addr", 32'(addr_log[i]), 32'(exp_a0[i]));
    for (int i = 0; i < 6 && i < lane_log.size(); i++) check("m0_lane", 32'(lane_log[i]), 32'(exp_l0[i]));

    // Mode 1, four windows: linear addresses, alternating lane halves.
    mode = 2'd1; base_a = 21'h3F0; base_b = 21'h000; active = 1'b1;
    addr_log.delete(); lane_log.delete();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle_steps(8);
    wend(1'b1);
    idle_steps(8);
    wend(1'b1);
    idle_steps(8);
    wend(1'b1);
    idle_steps(8);
    wend(1'b0);
    check("m1_naddr", 32'(addr_log.size()), 8);
    check("m1_nlane", 32'(lane_log.size()), 8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) check("m1_addr", 32'(addr_log[i]), 32'h3F0 + 32'(i));
    for (int i = 0; i < 8 && i < lane_log.size(); i++)
      check("m1_lane", 32'(lane_log[i]), (i % 2 == 0) ? 32'b0011_10 : 32'b1100_00);
    auto_en = 1'b0;

    // Underrun: second accept withheld past cycle_stb, one word outstanding.
    mode = 2'd1; base_a = 21'h050; active = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ur_req", 32'(video_req), 1);
    check("ur_addr0", 32'(video_addr), 32'h050);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("ur_addr1", 32'(video_addr), 32'h051);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ur_pulse", 32'(underrun), 1);
    check("ur_fetch", 32'(fetch_stb), 1);
    check("ur_req_drop", 32'(video_req), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ur_once", 32'(underrun), 0);
    check("ur_busy", 32'(busy), 1);
    check("ur_req_wait", 32'(video_req), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ur_fsel", 32'(f_sel), 32'b0011);
    check("ur_bsel", 32'(b_sel), 32'b10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ur_req_hold", 32'(video_req), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ur_next_req", 32'(video_req), 1);
    check("ur_next_addr", 32'(video_addr), 32'h051);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ur_next_addr2", 32'(video_addr), 32'h052);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // line_start in WAIT with one word still outstanding.
    mode = 2'd0; base_a = 21'h1A0; base_b = 21'h2B0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ls_nofetch0", 32'(fetch_stb), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ls_nofetch1", 32'(fetch_stb), 0);
    check("ls_req_drain", 32'(video_req), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ls_req", 32'(video_req), 1);
    check("ls_addr_a", 32'(video_addr), 32'h1A0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ls_addr_b", 32'(video_addr), 32'h2B0);
    check("ls_fsel", 32'(f_sel), 32'b0001);
    check("ls_bsel_col0", 32'(b_sel), 32'b00);
    check("ls_busy", 32'(busy), 1);

    // Async reset mid-REQ with a queued word, away from any clock edge.
    #2 res = 1'b1;
    #1;
    check_zero("async");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    res = 1'b0;
    idle_steps(3);
    check("post_rst_req", 32'(video_req), 0);
    check("post_rst_busy", 32'(busy), 0);
    mode = 2'd1; base_a = 21'h0AA;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_req", 32'(video_req), 1);
    check("restart_addr", 32'(video_addr), 32'h0AA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
